rio_link_tx_arb: RTL and testbench

//  Packet-level round-robin arbiter and credit scheduler in front of the RIO link TX controller.

---
 rtl/rio_link_tx_arb_pkg.sv | 11 +
 rtl/rio_link_tx_arb_rr_pick.sv | 31 +++
 rtl/rio_link_tx_arb.sv | 144 ++++++++++++++
 tb/tb_rio_link_tx_arb.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rio_link_tx_arb_pkg.sv
// Shared types for the RIO link TX arbiter.
//   arb_state_t : packet-grant FSM state (IDLE -> GRANT -> STREAM -> IDLE)
package rio_link_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // no grant, waiting for a buffered packet, link ready and credits
        ST_GRANT  = 2'd1,  // source chosen, waiting for its SOP word to be taken
        ST_STREAM = 2'd2   // SOP taken, words flow every cycle until EOP
    } arb_state_t;

endpackage

// File: rtl/rio_link_tx_arb_rr_pick.sv
// Combinational round-robin picker.
//   req     : per-source request vector
//   last    : index granted last time; search starts at last+1 and wraps
//   gnt_idx : index of the first requesting source found
//   any     : at least one request present (gnt_idx valid)
module rio_link_tx_arb_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last,
    output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_SRC);

    int k;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            k = (int'(last) + i) % NUM_SRC;
            if (!any && req[IW'(k)]) begin
                any     = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/rio_link_tx_arb.sv
// Packet-level round-robin arbiter and credit scheduler in front of the
// RIO link TX controller. A source is granted only when the credit count
// covers a maximum-size packet, and the grant is held from SOP to EOP.
//   clk, rst           : clock, asynchronous active-high reset
//   i_src_valid/sop/eop: per-source word strobes
//   i_src_data         : per-source data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_src_rdy          : one-hot word-consumed strobe to the granted source
//   o_tx_*             : combinational mux towards the TX controller
//   i_tx_rdy           : TX controller idle and link up
//   i_cred_ret_valid/i_cred_ret : credit return from the RX side
//   o_credits          : registered credit count
//   o_grant            : current or last granted source
//   o_busy             : grant held
//   o_err              : sticky mid-packet bubble or credit underflow
module rio_link_tx_arb
    import rio_link_tx_arb_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int CRED_WIDTH    = 16,
    parameter int CRED_INIT     = 0,
    parameter int CRED_MAX      = 1024,
    parameter int MAX_PKT_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    input  logic [NUM_SRC-1:0]            i_src_sop,
    input  logic [NUM_SRC-1:0]            i_src_eop,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
    output logic [NUM_SRC-1:0]            o_src_rdy,
    output logic                          o_tx_valid,
    output logic                          o_tx_sop,
    output logic                          o_tx_eop,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    input  logic                          i_tx_rdy,
    input  logic                          i_cred_ret_valid,
    input  logic [CRED_WIDTH-1:0]         i_cred_ret,
    output logic [CRED_WIDTH-1:0]         o_credits,
    output logic [$clog2(NUM_SRC)-1:0]    o_grant,
    output logic                          o_busy,
    output logic                          o_err
);
    localparam int IW = $clog2(NUM_SRC);
    localparam logic [CRED_WIDTH-1:0] PKT_NEED = CRED_WIDTH'(MAX_PKT_WORDS);
    localparam logic [CRED_WIDTH:0]   CRED_TOP = (CRED_WIDTH+1)'(CRED_MAX);

    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
    assign src_data = i_src_data;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   grant_q, last_q, pick_idx;
    logic [NUM_SRC-1:0] cand;
    logic            pick_any, arb_go;
    logic            word_take, bubble, cred_uf;
    logic [CRED_WIDTH-1:0] inc, cred_d;
    logic [CRED_WIDTH:0]   cred_sum;

    assign cand = i_src_valid & i_src_sop;

    rio_link_tx_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req     (cand),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign arb_go = (state_q == ST_IDLE) && pick_any && i_tx_rdy && (o_credits >= PKT_NEED);

    // Next state and output mux
    always_comb begin
        state_d    = state_q;
        o_src_rdy  = '0;
        o_tx_valid = 1'b0;
        o_tx_sop   = 1'b0;
        o_tx_eop   = 1'b0;
        o_tx_data  = '0;
        word_take  = 1'b0;
        bubble     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_go) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                o_tx_valid = i_src_valid[grant_q] & i_src_sop[grant_q];
                o_tx_sop   = 1'b1;
                o_tx_eop   = i_src_eop[grant_q];
                o_tx_data  = src_data[grant_q];
                word_take  = i_src_valid[grant_q] & i_src_sop[grant_q] & i_tx_rdy;
                if (word_take) begin
                    o_src_rdy[grant_q] = 1'b1;
                    state_d = i_src_eop[grant_q] ? ST_IDLE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                // The TX controller is committed mid-packet, so i_tx_rdy is not consulted.
                o_src_rdy[grant_q] = 1'b1;
                o_tx_valid = i_src_valid[grant_q];
                o_tx_eop   = i_src_eop[grant_q];
                o_tx_data  = src_data[grant_q];
                word_take  = i_src_valid[grant_q];
                bubble     = ~i_src_valid[grant_q];
                if (i_src_valid[grant_q] && i_src_eop[grant_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Credit counter: add return and subtract consumed word one bit wider,
    // then clamp at the ceiling; a take from an empty counter is an error.
    always_comb begin
        inc      = i_cred_ret_valid ? i_cred_ret : '0;
        cred_sum = {1'b0, o_credits} + {1'b0, inc};
        cred_uf  = (o_credits == '0) && word_take && (inc == '0);
        cred_d   = o_credits;
        if (!cred_uf) begin
            cred_sum = cred_sum - {{CRED_WIDTH{1'b0}}, word_take};
            if (cred_sum > CRED_TOP) cred_sum = CRED_TOP;
            cred_d = cred_sum[CRED_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_SRC - 1);  // source 0 wins the first arbitration
            o_credits <= CRED_WIDTH'(CRED_INIT);
            o_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_credits <= cred_d;
            if (arb_go) begin
                grant_q <= pick_idx;
                last_q  <= pick_idx;
            end
            if (bubble || cred_uf) o_err <= 1'b1;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rio_link_tx_arb.sv
// Self-checking bench for rio_link_tx_arb: directed scenarios followed by a
// randomized run, all checked against a packet-level source/credit model.
module tb_rio_link_tx_arb;
    localparam int NS = 4;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int CI = 0;
    localparam int CM = 1024;
    localparam int MP = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NS-1:0]    src_valid, src_sop, src_eop, src_rdy;
    logic [NS*DW-1:0] src_data;
    logic             tx_valid, tx_sop, tx_eop, tx_rdy, cred_ret_valid, busy, err;
    logic [DW-1:0]    tx_data;
    logic [CW-1:0]    cred_ret, credits;
    logic [1:0]       grant;

    rio_link_tx_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CRED_WIDTH(CW), .CRED_INIT(CI),
                      .CRED_MAX(CM), .MAX_PKT_WORDS(MP)) dut (
        .clk(clk), .rst(rst),
        .i_src_valid(src_valid), .i_src_sop(src_sop), .i_src_eop(src_eop), .i_src_data(src_data),
        .o_src_rdy(src_rdy),
        .o_tx_valid(tx_valid), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop), .o_tx_data(tx_data),
        .i_tx_rdy(tx_rdy),
        .i_cred_ret_valid(cred_ret_valid), .i_cred_ret(cred_ret),
        .o_credits(credits), .o_grant(grant), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Source model: each source holds at most one fully buffered packet.
    int plen[NS], ppos[NS], pnum[NS], rdy_cnt[NS];
    bit have[NS], hole[NS];
    bit refill = 0, rnd = 0, ret_v = 0, exp_err = 0;
    int max_len = 4, ret_amt = 0;
    int cur = -1, rr_last = NS - 1, exp_cred = CI;
    int order_q[$];

    function automatic logic [DW-1:0] word(int k);
        return {4'(k), 4'(pnum[k]), 8'(ppos[k])};
    endfunction

    function automatic int next_rr();
        for (int i = 1; i <= NS; i++) begin
            int k = (rr_last + i) % NS;
            if (have[k]) return k;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < NS; k++) if (have[k]) n++;
        return n;
    endfunction

    task automatic drive();
        for (int k = 0; k < NS; k++) begin
            src_valid[k] = have[k] && !hole[k];
            src_sop[k]   = (ppos[k] == 0);
            src_eop[k]   = (ppos[k] == plen[k] - 1);
            src_data[k*DW +: DW] = word(k);
        end
        cred_ret_valid = ret_v;
        cred_ret       = CW'(ret_amt);
    endtask

    task automatic add_pkt(int k, int len);
        have[k] = 1; plen[k] = len; ppos[k] = 0;
    endtask

    // One clock: drive, check the combinational side at negedge, advance the
    // model, then check the registered side just after the edge.
    task automatic step();
        int g, take, ret;
        if (rnd) begin
            tx_rdy  = ($urandom_range(3) != 0);
            ret_v   = ($urandom_range(9) < 3);
            ret_amt = $urandom_range(6);
        end
        drive();
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NS; k++) if (src_rdy[k]) g = k;
        chk("rdy_onehot", 32'($countones(src_rdy) <= 1), 1);
        if (cur >= 0) begin
            chk("stream_rdy", 32'(src_rdy[cur]), 1);
        end
        take = 0;
        if (g >= 0) begin
            rdy_cnt[g]++;
            if (src_valid[g]) begin
                take = 1;
                if (ppos[g] == 0) begin
                    chk("rr_order", 32'(g), 32'(next_rr()));
                    chk("sop_tx_rdy", 32'(tx_rdy), 1);
                    rr_last = g;
                    order_q.push_back(g);
                end
                chk("tx_valid", 32'(tx_valid), 1);
                chk("tx_sop", 32'(tx_sop), 32'(ppos[g] == 0));
                chk("tx_eop", 32'(tx_eop), 32'(ppos[g] == plen[g] - 1));
                chk("tx_data", 32'(tx_data), 32'(word(g)));
                chk("grant", 32'(grant), 32'(g));
            end else begin
                chk("bubble_src", 32'(g), 32'(cur));
                exp_err = 1;
            end
        end
        ret = ret_v ? ret_amt : 0;
        if (exp_cred == 0 && take == 1 && ret == 0) exp_err = 1;
        else begin
            exp_cred = exp_cred + ret - take;
            if (exp_cred > CM) exp_cred = CM;
        end
        if (take == 1) begin
            ppos[g]++;
            if (ppos[g] == plen[g]) begin
                ppos[g] = 0; pnum[g]++; cur = -1; have[g] = refill;
                if (refill) plen[g] = $urandom_range(max_len, 1);
            end else cur = g;
        end
        if (!rnd) ret_v = 0;
        @(posedge clk);
        #1;
        chk("credits", 32'(credits), 32'(exp_cred));
        chk("err", 32'(err), 32'(exp_err));
    endtask

    task automatic give_credits(int n);
        ret_v = 1; ret_amt = n;
        step();
    endtask

    task automatic drain(int limit);
        int n = 0;
        while (n < limit && (pending() != 0 || busy)) begin
            step();
            n++;
        end
        chk("drain_busy", 32'(busy), 0);
        chk("drain_pending", 32'(pending()), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        refill = 0; rnd = 0; ret_v = 0; tx_rdy = 1;
        for (int k = 0; k < NS; k++) begin
            have[k] = 0; hole[k] = 0; ppos[k] = 0; rdy_cnt[k] = 0;
        end
        cur = -1; rr_last = NS - 1; exp_cred = CI; exp_err = 0;
        drive();
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_sop", 32'(tx_sop), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_src_rdy", 32'(src_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_credits", 32'(credits), 32'(CI));
        chk("rst_grant", 32'(grant), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < NS; k++) begin pnum[k] = 0; plen[k] = 1; end
        tx_rdy = 1;

        // 1: no credits -> no grant; 16 returned -> grant, 4 words, 12 left
        do_reset();
        add_pkt(0, 4);
        repeat (5) begin
            step();
            chk("t1_no_grant", 32'(busy), 0);
        end
        give_credits(16);
        chk("t1_cred16", 32'(credits), 16);
        step();
        chk("t1_grant_busy", 32'(busy), 1);
        chk("t1_grant_src", 32'(grant), 0);
        drain(20);
        chk("t1_cred12", 32'(credits), 12);
        chk("t1_words", 32'(rdy_cnt[0]), 4);

        // 2: all sources requesting continuously -> 0,1,2,3,0
        do_reset();
        give_credits(1000);
        order_q.delete();
        refill = 1; max_len = 4;
        for (int k = 0; k < NS; k++) add_pkt(k, $urandom_range(4, 1));
        n = 0;
        while (order_q.size() < 6 && n < 200) begin step(); n++; end
        refill = 0;
        drain(60);
        chk("t2_count", 32'(order_q.size() >= 5), 1);
        if (order_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t2_order", 32'(order_q[i]), 32'(i % NS));
        end

        // 3: single-word packet from src2
        do_reset();
        give_credits(100);
        add_pkt(2, 1);
        step();
        chk("t3_busy", 32'(busy), 1);
        step();
        chk("t3_idle", 32'(busy), 0);
        chk("t3_rdy_once", 32'(rdy_cnt[2]), 1);
        chk("t3_cred", 32'(credits), 99);
        repeat (2) step();
        chk("t3_rdy_still_once", 32'(rdy_cnt[2]), 1);

        // 4: return and consume in the same cycle; saturation at CRED_MAX
        do_reset();
        give_credits(20);
        add_pkt(0, 4);
        step();
        chk("t4_busy", 32'(busy), 1);
        ret_v = 1; ret_amt = 5;
        step();
        chk("t4_cred24", 32'(credits), 24);
        drain(20);
        give_credits(2000);
        chk("t4_sat", 32'(credits), 32'(CM));
        give_credits(7);
        chk("t4_sat_hold", 32'(credits), 32'(CM));

        // 5: src1 bubble mid-STREAM
        do_reset();
        give_credits(100);
        add_pkt(1, 6);
        n = 0;
        while (ppos[1] < 2 && n < 20) begin step(); n++; end
        hole[1] = 1;
        step();
        chk("t5_err", 32'(err), 1);
        chk("t5_busy", 32'(busy), 1);
        step();
        chk("t5_busy_hold", 32'(busy), 1);
        hole[1] = 0;
        drain(20);
        chk("t5_err_sticky", 32'(err), 1);

        // 6: reset during STREAM, then source 0 has priority again
        do_reset();
        give_credits(100);
        add_pkt(0, 8);
        n = 0;
        while (ppos[0] < 3 && n < 20) begin step(); n++; end
        chk("t6_busy_pre", 32'(busy), 1);
        do_reset();
        chk("t6_cred_init", 32'(credits), 32'(CI));
        give_credits(100);
        order_q.delete();
        add_pkt(0, 3);
        add_pkt(1, 3);
        drain(40);
        chk("t6_two_pkts", 32'(order_q.size()), 2);
        if (order_q.size() >= 1) chk("t6_first", 32'(order_q[0]), 0);

        // 7: packet longer than MAX_PKT_WORDS underflows the counter
        do_reset();
        give_credits(16);
        add_pkt(3, 17);
        drain(30);
        chk("t7_err", 32'(err), 1);
        chk("t7_cred0", 32'(credits), 0);

        // Randomized traffic: random link readiness and credit returns
        do_reset();
        give_credits(40);
        refill = 1; max_len = MP; rnd = 1;
        for (int k = 0; k < NS; k++) add_pkt(k, $urandom_range(MP, 1));
        repeat (1500) step();
        rnd = 0; ret_v = 0; tx_rdy = 1; refill = 0;
        give_credits(500);
        drain(300);
        chk("rnd_no_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
